add16_share_arb: RTL and testbench

ADD16_SHARE_ARB -- requirements
Module: add16_share_arb

---
 rtl/add16_share_arb_if.sv | 28 ++
 rtl/add16_share_arb.sv | 121 ++++++++++++
 tb/tb_add16_share_arb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add16_share_arb_if.sv
// Request/response bundle for the shared nibble-serial adder: two requesters
// in, one tagged result out.
interface add16_share_arb_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/add16_share_arb.sv
// Two-requester round-robin front end around one 4-bit ripple adder; a W-bit
// add is done serially, one nibble per cycle, with the carry held in a register.
module FA_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module FA_4bit_Using_1bit_FA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    FA_1bit u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
  end
  assign cout = c[4];
endmodule

module add16_share_arb #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  add16_share_arb_if.slave       bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t                   state;
  logic [KW-1:0]            k;
  logic                     carry, last_grant;
  logic [NIBBLES-1:0][3:0]  a_q, b_q, res_q, res_nxt;
  logic [3:0]               add_sum;
  logic                     add_cout;
  logic                     grant1, acc0, acc1;
  logic                     rsp_valid_q, rsp_id_q, rsp_cout_q;
  logic [W-1:0]             rsp_sum_q;

  // On a tie, the requester that did not own the previous result wins.
  always_comb begin
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    acc0   = rst_n && (state == IDLE) && bus.req0_valid && !grant1;
    acc1   = rst_n && (state == IDLE) && bus.req1_valid && grant1;
  end

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_cout   = rsp_cout_q;

  FA_4bit_Using_1bit_FA u_add (
    .a(a_q[k]), .b(b_q[k]), .cin(carry), .sum(add_sum), .cout(add_cout)
  );

  always_comb begin
    res_nxt    = res_q;
    res_nxt[k] = add_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      carry       <= 1'b0;
      last_grant  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc0 || acc1) begin
          a_q      <= acc1 ? bus.req1_a   : bus.req0_a;
          b_q      <= acc1 ? bus.req1_b   : bus.req0_b;
          carry    <= acc1 ? bus.req1_cin : bus.req0_cin;
          rsp_id_q <= acc1;
          k        <= '0;
          res_q    <= '0;
          state    <= CALC;
        end
        CALC: begin
          res_q <= res_nxt;
          carry <= add_cout;
          // k stops at the last nibble rather than wrapping.
          if (k == K_LAST) begin
            rsp_sum_q   <= res_nxt;
            rsp_cout_q  <= add_cout;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            k <= k + KW'(1);
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          last_grant  <= rsp_id_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add16_share_arb.sv
// Scoreboard bench for add16_share_arb: expected {id,cout,sum} queued at accept,
// checked by a monitor at every response handshake.
module tb_add16_share_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add16_share_arb_if #(.NIBBLES(4)) ifc ();
  add16_share_arb #(.NIBBLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  int vectors = 0;
  int miscompares = 0;
  logic [17:0] sb[$];
  logic [17:0] mon_exp;

  function automatic logic [17:0] model(bit id, logic [15:0] a, logic [15:0] b, bit cin);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    return {id, s};
  endfunction

  always @(negedge clk) begin
    if (rst_n && ifc.rsp_valid && ifc.rsp_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected got id=%0d cout=%0d sum=%h with empty scoreboard",
                 ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum);
      end else begin
        mon_exp = sb.pop_front();
        if ({ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum} !== mon_exp) begin
          miscompares++;
          $display("FAIL rsp_data got id=%0d cout=%0d sum=%h exp id=%0d cout=%0d sum=%h",
                   ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum, mon_exp[17], mon_exp[16], mon_exp[15:0]);
        end
      end
    end
  end

  task automatic idle_inputs();
    ifc.req0_valid = 1'b0; ifc.req0_a = '0; ifc.req0_b = '0; ifc.req0_cin = 1'b0;
    ifc.req1_valid = 1'b0; ifc.req1_a = '0; ifc.req1_b = '0; ifc.req1_cin = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    ifc.rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ifc.req1_ready, ifc.req0_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready got %b exp 00", {ifc.req1_ready, ifc.req0_ready});
    end
    vectors++;
    if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_rsp got valid=%0d id=%0d cout=%0d sum=%h exp all zero",
               ifc.rsp_valid, ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One transaction from requester id with rsp_ready high; checks grant,
  // CALC duration, latency and response drop.
  task automatic test_single(input bit id, input logic [15:0] a, input logic [15:0] b,
                             input bit cin, input string name);
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1;
    if (id) begin
      ifc.req1_a = a; ifc.req1_b = b; ifc.req1_cin = cin; ifc.req1_valid = 1'b1;
    end else begin
      ifc.req0_a = a; ifc.req0_b = b; ifc.req0_cin = cin; ifc.req0_valid = 1'b1;
    end
    @(negedge clk);
    vectors++;
    if ({ifc.req1_ready, ifc.req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL %s_grant got %b exp %b", name, {ifc.req1_ready, ifc.req0_ready},
               id ? 2'b10 : 2'b01);
    end
    sb.push_back(model(id, a, b, cin));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({ifc.rsp_valid, ifc.req1_ready, ifc.req0_ready} !== 3'b000) begin
        miscompares++;
        $display("FAIL %s_calc cycle %0d got valid/ready %b exp 000", name, i,
                 {ifc.rsp_valid, ifc.req1_ready, ifc.req0_ready});
      end
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc.rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_latency got rsp_valid=%0d exp 1", name, ifc.rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if (ifc.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_rsp_drop got rsp_valid=%0d exp 0", name, ifc.rsp_valid);
    end
  endtask

  // Both requesters held valid; the bench's own round-robin model predicts
  // each grant. First req1 operand set is 0x8000 + 0x8000.
  task automatic test_arbitration(input int n);
    logic [15:0] a0, b0, a1, b1;
    bit c0, c1, mdl_last, exp_id;
    int n_acc, cyc;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    a0 = 16'h0123; b0 = 16'h4567; c0 = 1'b0;
    a1 = 16'h8000; b1 = 16'h8000; c1 = 1'b0;
    ifc.req0_a = a0; ifc.req0_b = b0; ifc.req0_cin = c0; ifc.req0_valid = 1'b1;
    ifc.req1_a = a1; ifc.req1_b = b1; ifc.req1_cin = c1; ifc.req1_valid = 1'b1;
    ifc.rsp_ready = 1'b1;
    mdl_last = 1'b1; n_acc = 0; cyc = 0;
    while (n_acc < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ifc.req0_ready || ifc.req1_ready) begin
        exp_id = ~mdl_last;
        vectors++;
        if ({ifc.req1_ready, ifc.req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL arb_grant txn %0d got %b exp %b", n_acc,
                   {ifc.req1_ready, ifc.req0_ready}, exp_id ? 2'b10 : 2'b01);
        end
        sb.push_back(exp_id ? model(1'b1, a1, b1, c1) : model(1'b0, a0, b0, c0));
        mdl_last = exp_id;
        n_acc++;
        @(posedge clk); #1;
        if (exp_id) begin
          a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
          ifc.req1_a = a1; ifc.req1_b = b1; ifc.req1_cin = c1;
        end else begin
          a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom);
          ifc.req0_a = a0; ifc.req0_b = b0; ifc.req0_cin = c0;
        end
      end
    end
    idle_inputs();
    vectors++;
    if (n_acc != n) begin
      miscompares++;
      $display("FAIL arb_count got %0d accepts exp %0d", n_acc, n);
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL arb_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp;
    int cyc;
    exp = model(1'b0, 16'hABCD, 16'h1234, 1'b1);
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    ifc.req0_a = 16'hABCD; ifc.req0_b = 16'h1234; ifc.req0_cin = 1'b1; ifc.req0_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (ifc.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_grant got req0_ready=%0d exp 1", ifc.req0_ready);
    end
    sb.push_back(exp);
    @(posedge clk); #1;
    ifc.req0_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ifc.rsp_valid !== 1'b1 && cyc < 20);
    vectors++;
    if (ifc.rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_timeout got rsp_valid=%0d exp 1 within 20 cycles", ifc.rsp_valid);
    end
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL bp_hold got valid=%0d id=%0d cout=%0d sum=%h exp 1/%0d/%0d/%h",
                 ifc.rsp_valid, ifc.rsp_id, ifc.rsp_cout, ifc.rsp_sum, exp[17], exp[16], exp[15:0]);
      end
      vectors++;
      if ({ifc.req1_ready, ifc.req0_ready} !== 2'b00) begin
        miscompares++;
        $display("FAIL bp_ready got %b exp 00", {ifc.req1_ready, ifc.req0_ready});
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ifc.rsp_valid !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_complete got rsp_valid=%0d pending=%0d exp 0/0", ifc.rsp_valid, sb.size());
    end
  endtask

  task automatic test_reset_mid_calc();
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1;
    ifc.req1_a = 16'h5555; ifc.req1_b = 16'hAAAA; ifc.req1_cin = 1'b1; ifc.req1_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ifc.req1_ready, ifc.req0_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid_grant got %b exp 10", {ifc.req1_ready, ifc.req0_ready});
    end
    @(posedge clk); #1;
    ifc.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (ifc.rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_no_rsp cycle %0d got rsp_valid=%0d exp 0", i, ifc.rsp_valid);
      end
    end
    test_single(1'b0, 16'h00FF, 16'h0F01, 1'b0, "post_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    ifc.rsp_ready = 1'b1;
    test_reset();
    test_single(1'b0, 16'h1234, 16'h0FCD, 1'b0, "req0");
    test_single(1'b1, 16'hFFFF, 16'h0000, 1'b1, "req1");
    test_single(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "max");
    test_arbitration(6);
    test_backpressure();
    test_reset_mid_calc();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
